// File: rtl/mul_hilo_ctrl_if.sv
// Operand, product and HI/LO access bundle between a core and the multiply controller.
interface mul_hilo_ctrl_if;
    localparam int unsigned W = 32;

    logic           start;
    logic [W-1:0]   op_x;
    logic [W-1:0]   op_y;
    logic [W-1:0]   mul_x;
    logic [W-1:0]   mul_y;
    logic [2*W-1:0] mul_result;
    logic           busy;
    logic           done;
    logic [W-1:0]   hi_in;
    logic [W-1:0]   lo_in;
    logic           hi_we;
    logic           lo_we;
    logic [W-1:0]   hi_out;
    logic [W-1:0]   lo_out;

    modport slave (
        input  start, op_x, op_y, mul_result, hi_in, lo_in, hi_we, lo_we,
        output mul_x, mul_y, busy, done, hi_out, lo_out
    );

    modport master (
        output start, op_x, op_y, mul_result, hi_in, lo_in, hi_we, lo_we,
        input  mul_x, mul_y, busy, done, hi_out, lo_out
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Sequences an external combinational multiplier: registers operands, waits a fixed
// settle time, then splits the 64-bit product into the HI/LO register pair.
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 clear,
    mul_hilo_ctrl_if.slave       bus
);
    localparam int unsigned W     = 32;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       mul_x_q, mul_x_d;
    logic [W-1:0]       mul_y_q, mul_y_d;
    logic [W-1:0]       hi_q, hi_d;
    logic [W-1:0]       lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Next-state and datapath; HI/LO are writable only while no multiply is in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_x_d = mul_x_q;
        mul_y_d = mul_y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.hi_we) hi_d = bus.hi_in;
                if (bus.lo_we) lo_d = bus.lo_in;
                if (bus.start) begin
                    mul_x_d = bus.op_x;
                    mul_y_d = bus.op_y;
                    cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    hi_d    = bus.mul_result[2*W-1:W];
                    lo_d    = bus.mul_result[W-1:0];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags are pure decodes of the state they will accompany.
        busy_d = (state_d == SETTLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mul_x_q <= '0;
            mul_y_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_x_q <= mul_x_d;
            mul_y_q <= mul_y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mul_x  = mul_x_q;
    assign bus.mul_y  = mul_y_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl: two instances (settle 2 and 4) with a Booth multiplier
// model, scoreboard queues of expected {HI,LO} checked on each done pulse.
module tb_mul_hilo_ctrl;
    logic clock;
    logic clear2;
    logic clear4;

    int tests = 0;
    int fails = 0;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    mul_hilo_ctrl_if ifc2 ();
    mul_hilo_ctrl_if ifc4 ();

    mul_hilo_ctrl #(.SETTLE_CYCLES(2)) u_dut2 (.clock(clock), .clear(clear2), .bus(ifc2.slave));
    mul_hilo_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (.clock(clock), .clear(clear4), .bus(ifc4.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Radix-2 Booth recoding of y, accumulating shifted copies of sign-extended x.
    function automatic logic [63:0] booth(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] acc;
        logic [63:0] mcand;
        logic        prev;
        acc   = '0;
        mcand = {{32{x[31]}}, x};
        prev  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            case ({y[i], prev})
                2'b01:   acc = acc + (mcand << i);
                2'b10:   acc = acc - (mcand << i);
                default: acc = acc;
            endcase
            prev = y[i];
        end
        return acc;
    endfunction

    function automatic logic [63:0] smul(input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{x[31]}}, x};
        sb = {{32{y[31]}}, y};
        return 64'(sa * sb);
    endfunction

    always_comb ifc2.mul_result = booth(ifc2.mul_x, ifc2.mul_y);
    always_comb ifc4.mul_result = booth(ifc4.mul_x, ifc4.mul_y);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle(input bit d4);
        if (d4) begin
            ifc4.start = 1'b0; ifc4.hi_we = 1'b0; ifc4.lo_we = 1'b0;
        end else begin
            ifc2.start = 1'b0; ifc2.hi_we = 1'b0; ifc2.lo_we = 1'b0;
        end
    endtask

    // Accept edge E0: drive operands, record expected product, drop start after the edge.
    task automatic do_start(input bit d4, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] e);
        if (d4) begin
            ifc4.op_x = x; ifc4.op_y = y; ifc4.start = 1'b1; q4.push_back(e);
        end else begin
            ifc2.op_x = x; ifc2.op_y = y; ifc2.start = 1'b1; q2.push_back(e);
        end
        step();
        if (d4) ifc4.start = 1'b0; else ifc2.start = 1'b0;
    endtask

    task automatic wait_done(input bit d4, input int budget, input int exp_busy,
                             input string tag);
        int          n;
        bit          got;
        logic [63:0] e;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            if (d4 ? ifc4.done : ifc2.done) got = 1'b1;
            else begin
                if (d4 ? ifc4.busy : ifc2.busy) n++;
                step();
            end
        end
        chk({tag, "_done_seen"}, 64'(got), 64'd1);
        chk({tag, "_busy_cycles"}, 64'(n), 64'(exp_busy));
        if (got) begin
            if ((d4 ? q4.size() : q2.size()) == 0) begin
                chk({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            end else begin
                e = d4 ? q4.pop_front() : q2.pop_front();
                chk({tag, "_hi"}, 64'(d4 ? ifc4.hi_out : ifc2.hi_out), 64'(e[63:32]));
                chk({tag, "_lo"}, 64'(d4 ? ifc4.lo_out : ifc2.lo_out), 64'(e[31:0]));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear2 = 1'b1;
        clear4 = 1'b1;
        ifc2.op_x = '0; ifc2.op_y = '0; ifc2.hi_in = '0; ifc2.lo_in = '0;
        ifc4.op_x = '0; ifc4.op_y = '0; ifc4.hi_in = '0; ifc4.lo_in = '0;
        drive_idle(1'b0);
        drive_idle(1'b1);
        step();
        step();
        clear2 = 1'b0;
        clear4 = 1'b0;
        step();

        // Reset state
        chk("rst_busy", 64'(ifc2.busy), 64'd0);
        chk("rst_done", 64'(ifc2.done), 64'd0);
        chk("rst_hi", 64'(ifc2.hi_out), 64'd0);
        chk("rst_mulx", 64'(ifc2.mul_x), 64'd0);

        // Direct writes in IDLE
        ifc2.hi_we = 1'b1; ifc2.hi_in = 32'hDEADBEEF;
        ifc2.lo_we = 1'b1; ifc2.lo_in = 32'hCAFEF00D;
        step();
        drive_idle(1'b0);
        chk("wr_idle_hi", 64'(ifc2.hi_out), 64'h0000_0000_DEAD_BEEF);
        chk("wr_idle_lo", 64'(ifc2.lo_out), 64'h0000_0000_CAFE_F00D);

        // Asynchronous clear between edges, then inputs ignored while held
        clear2 = 1'b1;
        #1;
        chk("aclr_hi", 64'(ifc2.hi_out), 64'd0);
        chk("aclr_lo", 64'(ifc2.lo_out), 64'd0);
        ifc2.start = 1'b1; ifc2.op_x = 32'd9;
        ifc2.hi_we = 1'b1; ifc2.hi_in = 32'h1;
        step();
        chk("clr_hold_busy", 64'(ifc2.busy), 64'd0);
        chk("clr_hold_hi", 64'(ifc2.hi_out), 64'd0);
        chk("clr_hold_mulx", 64'(ifc2.mul_x), 64'd0);
        drive_idle(1'b0);
        clear2 = 1'b0;
        step();
        chk("post_clr_idle", 64'(ifc2.busy), 64'd0);

        // Basic multiply 3 * -5
        do_start(1'b0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);
        chk("basic_mulx", 64'(ifc2.mul_x), 64'd3);
        chk("basic_muly", 64'(ifc2.mul_y), 64'h0000_0000_FFFF_FFFB);
        wait_done(1'b0, 10, 2, "basic");
        step();
        chk("basic_done_1cyc", 64'(ifc2.done), 64'd0);

        // Start during SETTLE is ignored
        do_start(1'b0, 32'd7, 32'd6, 64'h0000_0000_0000_002A);
        ifc2.start = 1'b1; ifc2.op_x = 32'd1; ifc2.op_y = 32'd1;
        step();
        ifc2.start = 1'b0;
        chk("ign_mulx", 64'(ifc2.mul_x), 64'd7);
        chk("ign_muly", 64'(ifc2.mul_y), 64'd6);
        wait_done(1'b0, 10, 1, "ign");
        step();
        chk("ign_no_queue", 64'(ifc2.busy), 64'd0);

        // Back-to-back: second start issued in the DONE cycle
        do_start(1'b0, 32'd2, 32'd3, 64'd6);
        wait_done(1'b0, 10, 2, "b2b_a");
        do_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
        chk("b2b_no_idle", 64'(ifc2.busy), 64'd1);
        wait_done(1'b0, 10, 2, "b2b_b");
        step();
        chk("b2b_done_1cyc", 64'(ifc2.done), 64'd0);

        // Direct writes during SETTLE are dropped
        do_start(1'b0, 32'd5, 32'd5, 64'd25);
        ifc2.lo_we = 1'b1; ifc2.lo_in = 32'h12345678;
        ifc2.hi_we = 1'b1; ifc2.hi_in = 32'h87654321;
        step();
        drive_idle(1'b0);
        chk("wr_settle_lo", 64'(ifc2.lo_out), 64'd1);
        chk("wr_settle_hi", 64'(ifc2.hi_out), 64'd0);
        wait_done(1'b0, 10, 1, "wr_settle");
        step();

        // Direct write and accepted start on the same edge
        ifc2.hi_we = 1'b1; ifc2.hi_in = 32'hAAAA5555;
        do_start(1'b0, 32'd4, 32'hFFFF_FFFC, smul(32'd4, 32'hFFFF_FFFC));
        drive_idle(1'b0);
        chk("same_edge_hi", 64'(ifc2.hi_out), 64'h0000_0000_AAAA_5555);
        chk("same_edge_busy", 64'(ifc2.busy), 64'd1);
        wait_done(1'b0, 10, 2, "same_edge");
        step();

        // Settle-4 instance: abort mid-SETTLE then a fresh multiply
        ifc4.hi_we = 1'b1; ifc4.hi_in = 32'h11112222;
        ifc4.lo_we = 1'b1; ifc4.lo_in = 32'h33334444;
        step();
        drive_idle(1'b1);
        chk("d4_wr_hi", 64'(ifc4.hi_out), 64'h0000_0000_1111_2222);
        do_start(1'b1, 32'd9, 32'd9, 64'd81);
        step();
        clear4 = 1'b1;
        #1;
        chk("abort_busy", 64'(ifc4.busy), 64'd0);
        chk("abort_hi", 64'(ifc4.hi_out), 64'd0);
        chk("abort_lo", 64'(ifc4.lo_out), 64'd0);
        q4.delete();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abort_no_done", 64'(ifc4.done), 64'd0);
        end
        clear4 = 1'b0;
        step();
        do_start(1'b1, 32'd123456789, 32'hC521_974F, smul(32'd123456789, 32'hC521_974F));
        wait_done(1'b1, 20, 4, "d4_fresh");
        step();
        chk("d4_done_1cyc", 64'(ifc4.done), 64'd0);
        chk("sb_drained", 64'(q2.size() + q4.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
